// File: rtl/pooling_pkg.sv
// Shared types, widths and helpers for the pooling row sender.
package pooling_pkg;

  function automatic int logb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {
    FILL,
    SEND
  } state_t;

  localparam int INPUT_SIZE_DEF    = 6;
  localparam int KERNEL_SIZE_DEF   = 2;
  localparam int TOTAL_FEATURE_DEF = 4;

  localparam int ROW_WIDTH     = logb2(INPUT_SIZE_DEF);
  localparam int FEATURE_WIDTH = logb2(TOTAL_FEATURE_DEF);
  localparam int COL_WIDTH     = logb2(INPUT_SIZE_DEF);

endpackage

// File: rtl/pooling_row_buffer.sv
// KERNEL_SIZE x INPUT_SIZE pixel store.
// One pixel written per cycle; one column read combinationally.
module pooling_row_buffer
  import pooling_pkg::*;
#(
  parameter int INPUT_SIZE  = 6,
  parameter int KERNEL_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  localparam int RW = logb2(KERNEL_SIZE),
  localparam int CW = logb2(INPUT_SIZE)
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [RW-1:0]                   wr_row,
  input  logic [CW-1:0]                   wr_col,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [CW-1:0]                   rd_col,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [KERNEL_SIZE][INPUT_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [KERNEL_SIZE][INPUT_SIZE];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_row][wr_col] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Row 0 lands in the least significant lane.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < KERNEL_SIZE; k++)
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_col];
  end

endmodule

// File: rtl/pooling_row_sender.sv
// Buffers KERNEL_SIZE rows of a feature map and replays them
// as tagged column slices for the pooling channel.
module pooling_row_sender
  import pooling_pkg::*;
#(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] data_out,
  output logic [logb2(TOTAL_FEATURE)-1:0]   feature_idx,
  output logic [logb2(INPUT_SIZE)-1:0]      feature_row,
  output logic                              frame_done
);

  localparam int CW = logb2(INPUT_SIZE);
  localparam int RW = logb2(KERNEL_SIZE);
  localparam int FW = logb2(TOTAL_FEATURE);
  localparam int OW = KERNEL_SIZE * DATA_WIDTH;

  localparam logic [CW-1:0] COL_LAST  = CW'(INPUT_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] GRP_LAST  = CW'(INPUT_SIZE - KERNEL_SIZE);
  localparam logic [CW-1:0] GRP_STEP  = CW'(KERNEL_SIZE);
  localparam logic [FW-1:0] FEAT_LAST = FW'(TOTAL_FEATURE - 1);

  if (INPUT_SIZE % KERNEL_SIZE != 0) begin : g_bad_size
    $error("INPUT_SIZE must be a multiple of KERNEL_SIZE");
  end
  if (INPUT_SIZE < 2 || KERNEL_SIZE < 1) begin : g_bad_dims
    $error("INPUT_SIZE must be >= 2 and KERNEL_SIZE >= 1");
  end

  state_t          state_q, state_d;
  logic [RW-1:0]   wr_row_q, wr_row_d;
  logic [CW-1:0]   wr_col_q, wr_col_d;
  logic [CW-1:0]   rd_col_q, rd_col_d;
  logic [CW-1:0]   grp_row_q, grp_row_d;
  logic [FW-1:0]   grp_feature_q, grp_feature_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   data_out_q, data_out_d;
  logic [FW-1:0]   feature_idx_q, feature_idx_d;
  logic [CW-1:0]   feature_row_q, feature_row_d;
  logic            frame_done_q, frame_done_d;
  logic            wr_en;
  logic            load;
  logic [OW-1:0]   col_data;

  assign in_ready    = (state_q == FILL);
  assign wr_en       = in_ready && in_valid;
  assign out_valid   = out_valid_q;
  assign data_out    = data_out_q;
  assign feature_idx = feature_idx_q;
  assign feature_row = feature_row_q;
  assign frame_done  = frame_done_q;

  pooling_row_buffer #(
    .INPUT_SIZE  (INPUT_SIZE),
    .KERNEL_SIZE (KERNEL_SIZE),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_row  (wr_row_q),
    .wr_col  (wr_col_q),
    .wr_data (in_data),
    .rd_col  (rd_col_d),
    .rd_data (col_data)
  );

  always_comb begin
    state_d       = state_q;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    rd_col_d      = rd_col_q;
    grp_row_d     = grp_row_q;
    grp_feature_d = grp_feature_q;
    out_valid_d   = 1'b0;
    data_out_d    = data_out_q;
    feature_idx_d = feature_idx_q;
    feature_row_d = feature_row_q;
    frame_done_d  = 1'b0;
    load          = 1'b0;
    unique case (state_q)
      FILL: begin
        if (wr_en) begin
          if (wr_col_q == COL_LAST) begin
            wr_col_d = '0;
            if (wr_row_q == ROW_LAST) begin
              wr_row_d = '0;
              rd_col_d = '0;
              state_d  = SEND;
              load     = 1'b1;
            end else begin
              wr_row_d = wr_row_q + 1'b1;
            end
          end else begin
            wr_col_d = wr_col_q + 1'b1;
          end
        end
      end
      SEND: begin
        // rd_col_q is the column currently on the output.
        if (rd_col_q == COL_LAST) begin
          rd_col_d = '0;
          state_d  = FILL;
          if (grp_row_q == GRP_LAST) begin
            grp_row_d = '0;
            if (grp_feature_q == FEAT_LAST)
              grp_feature_d = '0;
            else
              grp_feature_d = grp_feature_q + 1'b1;
          end else begin
            grp_row_d = grp_row_q + GRP_STEP;
          end
        end else begin
          rd_col_d = rd_col_q + 1'b1;
          load     = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    if (load) begin
      out_valid_d   = 1'b1;
      data_out_d    = col_data;
      feature_idx_d = grp_feature_q;
      feature_row_d = grp_row_q;
      frame_done_d  = (rd_col_d == COL_LAST) &&
                      (grp_row_q == GRP_LAST) &&
                      (grp_feature_q == FEAT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      rd_col_q      <= '0;
      grp_row_q     <= '0;
      grp_feature_q <= '0;
      out_valid_q   <= 1'b0;
      data_out_q    <= '0;
      feature_idx_q <= '0;
      feature_row_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      rd_col_q      <= rd_col_d;
      grp_row_q     <= grp_row_d;
      grp_feature_q <= grp_feature_d;
      out_valid_q   <= out_valid_d;
      data_out_q    <= data_out_d;
      feature_idx_q <= feature_idx_d;
      feature_row_q <= feature_row_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pooling_row_sender.sv
// Scoreboard bench for pooling_row_sender at default parameters.
module tb_pooling_row_sender;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] data_out;
  logic [1:0]  feature_idx;
  logic [2:0]  feature_row;
  logic        frame_done;

  pooling_row_sender #(
    .INPUT_SIZE    (6),
    .KERNEL_SIZE   (2),
    .TOTAL_FEATURE (4),
    .DATA_WIDTH    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .data_out    (data_out),
    .feature_idx (feature_idx),
    .feature_row (feature_row),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  f;
    logic [2:0]  r;
    logic        fd;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_beats = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [31:0] grp0_tbl [6] = '{32'h00060000, 32'h00070001,
                                32'h00080002, 32'h00090003,
                                32'h000A0004, 32'h000B0005};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int g, input int i);
    return 16'(g * 256 + i);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        exp_t e;
        n_beats++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(data_out), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 64'(data_out), 64'(e.d));
          chk("beat_fidx", 64'(feature_idx), 64'(e.f));
          chk("beat_frow", 64'(feature_row), 64'(e.r));
          chk("beat_fdone", 64'(frame_done), 64'(e.fd));
        end
      end else if (frame_done !== 1'b0) begin
        chk("fdone_idle", 64'(frame_done), 64'd0);
      end
    end
  end

  task automatic push_grp(input int g, input int nb, input logic [1:0] f,
                          input logic [2:0] r, input bit last_grp);
    exp_t e;
    for (int c = 0; c < nb; c++) begin
      e.d  = (g == 0) ? grp0_tbl[c] : {pix(g, 6 + c), pix(g, c)};
      e.f  = f;
      e.r  = r;
      e.fd = last_grp && (c == 5);
      sb.push_back(e);
    end
  endtask

  task automatic send_pixel(input logic [15:0] v, input int gap,
                            output int acc);
    logic rdy;
    acc = -1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 100; t++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic feed(input int g, input int max_gap,
                      output int first_acc, output int last_acc);
    int a;
    first_acc = -1;
    for (int i = 0; i < 12; i++) begin
      send_pixel(pix(g, i),
                 (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, a);
      if (i == 0) first_acc = a;
    end
    last_acc = a;
  endtask

  initial begin
    int fa, la, la_prev;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_feature_idx", 64'(feature_idx), 64'd0);
    chk("rst_feature_row", 64'(feature_row), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    mon_en = 1;

    push_grp(0, 6, 2'd0, 3'd0, 1'b0);
    feed(0, 0, fa, la);
    chk("in_ready_low_send", 64'(in_ready), 64'd0);
    chk("first_beat_latency", 64'(out_valid), 64'd1);
    la_prev = la;

    push_grp(1, 6, 2'd0, 3'd2, 1'b0);
    feed(1, 0, fa, la);
    chk("resume_after_send", 64'(fa - la_prev), 64'd7);

    for (int g = 2; g < 12; g++) begin
      push_grp(g, 6, 2'(g / 3), 3'((g % 3) * 2), g == 11);
      feed(g, (g == 2) ? 3 : (g % 2), fa, la);
    end

    push_grp(12, 3, 2'd0, 3'd0, 1'b0);
    feed(12, 0, fa, la);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);

    push_grp(13, 6, 2'd0, 3'd0, 1'b0);
    feed(13, 1, fa, la);

    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("beat_count", 64'(n_beats), 64'd81);
    chk("end_out_valid", 64'(out_valid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
